// File: rtl/pipeline_pkg.sv
// Definitions shared by the fetch/decode pipeline stages: the IF/ID state
// encoding, the bubble opcode, the immediate-marker bit and the register
// bundle that the IF/ID buffer presents to decode.
package pipeline_pkg;

  // Opcode injected wherever decode must see "no instruction". Fetch's clear
  // mux uses the same value, so both stages agree on what a bubble is.
  localparam logic [15:0] NOP_CODE = 16'h4000;

  // Bit of an instruction word that says "the next fetched word is my immediate".
  localparam int unsigned IMM_BIT = 0;

  // Width of the PC+1 path; the if_id_t bundle is sized by this constant.
  localparam int unsigned PC_W = 32;

  typedef enum logic {
    S_INSTR = 1'b0,
    S_IMM   = 1'b1
  } if_id_state_e;

  typedef struct packed {
    logic [15:0]     instr;
    logic [15:0]     imm;
    logic [PC_W-1:0] pc_plus_one;
    logic            valid;
    logic            has_imm;
  } if_id_t;

  // Register contents for a bubble: no instruction, no immediate, no PC.
  function automatic if_id_t make_bubble(input logic [15:0] nop);
    if_id_t b;
    b.instr       = nop;
    b.imm         = '0;
    b.pc_plus_one = '0;
    b.valid       = 1'b0;
    b.has_imm     = 1'b0;
    return b;
  endfunction

endpackage

// File: rtl/if_id_buffer.sv
// IF/ID pipeline register. Captures each fetched word with its PC+1 and
// presents a registered instruction/PC pair to decode. A word whose IMM_BIT
// is set is parked until the following fetched word arrives; that word is
// then attached as the instruction's 16-bit immediate.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_INSTR | next valid fetched word is an instruction
// S_IMM   | first word parked in pending_instr, next valid word is its immediate
//
// Priority on each edge: flush, then stall, then the normal update.
// The output bundle type is sized by pipeline_pkg::PC_W; PC_W here must match it.
module if_id_buffer #(
  parameter int unsigned IMM_BIT  = pipeline_pkg::IMM_BIT,
  parameter logic [15:0] NOP_CODE = pipeline_pkg::NOP_CODE,
  parameter int unsigned PC_W     = pipeline_pkg::PC_W
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            fetch_valid,
  input  logic [15:0]     instruction,
  input  logic [PC_W-1:0] pc_plus_one,
  input  logic            stall,
  input  logic            flush,
  output logic [15:0]     out_instruction,
  output logic [15:0]     out_immediate,
  output logic [PC_W-1:0] out_pc_plus_one,
  output logic            out_valid,
  output logic            out_has_imm,
  output logic            imm_pending
);

  import pipeline_pkg::if_id_state_e;
  import pipeline_pkg::S_INSTR;
  import pipeline_pkg::S_IMM;
  import pipeline_pkg::if_id_t;
  import pipeline_pkg::make_bubble;

  if_id_state_e state_q, state_d;
  logic [15:0]  pending_instr_q, pending_instr_d;
  if_id_t       out_q, out_d;

  // State, parked first word and output bundle; reset leaves a bubble in S_INSTR.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= S_INSTR;
      pending_instr_q <= '0;
      out_q           <= make_bubble(NOP_CODE);
    end else begin
      state_q         <= state_d;
      pending_instr_q <= pending_instr_d;
      out_q           <= out_d;
    end
  end

  // Next state, parked word and output bundle; everything holds by default.
  always_comb begin
    state_d         = state_q;
    pending_instr_d = pending_instr_q;
    out_d           = out_q;

    if (flush) begin
      state_d         = S_INSTR;
      pending_instr_d = '0;
      out_d           = make_bubble(NOP_CODE);
    end else if (!stall) begin
      unique case (state_q)
        S_INSTR: begin
          if (!fetch_valid) begin
            out_d = make_bubble(NOP_CODE);
          end else if (instruction[IMM_BIT]) begin
            // Park the first word; decode sees a bubble until the immediate arrives.
            pending_instr_d = instruction;
            out_d           = make_bubble(NOP_CODE);
            state_d         = S_IMM;
          end else begin
            out_d.instr       = instruction;
            out_d.imm         = '0;
            out_d.pc_plus_one = pc_plus_one;
            out_d.valid       = 1'b1;
            out_d.has_imm     = 1'b0;
          end
        end
        S_IMM: begin
          if (!fetch_valid) begin
            out_d = make_bubble(NOP_CODE);
          end else begin
            // The immediate word is raw data; its IMM_BIT is never looked at.
            // Its PC+1 is the sequential PC after both words.
            out_d.instr       = pending_instr_q;
            out_d.imm         = instruction;
            out_d.pc_plus_one = pc_plus_one;
            out_d.valid       = 1'b1;
            out_d.has_imm     = 1'b1;
            pending_instr_d   = '0;
            state_d           = S_INSTR;
          end
        end
        default: begin
          state_d         = S_INSTR;
          pending_instr_d = '0;
          out_d           = make_bubble(NOP_CODE);
        end
      endcase
    end
  end

  assign out_instruction = out_q.instr;
  assign out_immediate   = out_q.imm;
  assign out_pc_plus_one = out_q.pc_plus_one;
  assign out_valid       = out_q.valid;
  assign out_has_imm     = out_q.has_imm;
  assign imm_pending     = (state_q == S_IMM);

endmodule

// File: tb/tb_if_id_buffer.sv
// Directed bench for the IF/ID buffer. Each step drives one fetch cycle and
// pushes the expected decode-side view onto a scoreboard queue; the entry is
// popped and compared just after the clock edge that should produce it.
module tb_if_id_buffer;

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] imm;
    logic [31:0] pc;
    logic        valid;
    logic        has_imm;
    logic        pending;
  } obs_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_valid;
  logic [15:0] instruction;
  logic [31:0] pc_plus_one;
  logic        stall;
  logic        flush;
  logic [15:0] out_instruction;
  logic [15:0] out_immediate;
  logic [31:0] out_pc_plus_one;
  logic        out_valid;
  logic        out_has_imm;
  logic        imm_pending;

  int n_pass = 0;
  int n_fail = 0;

  obs_t  exp_q[$];
  string tag_q[$];

  localparam logic [15:0] NOP = 16'h4000;

  if_id_buffer dut (
    .clk             (clk),
    .reset           (reset),
    .fetch_valid     (fetch_valid),
    .instruction     (instruction),
    .pc_plus_one     (pc_plus_one),
    .stall           (stall),
    .flush           (flush),
    .out_instruction (out_instruction),
    .out_immediate   (out_immediate),
    .out_pc_plus_one (out_pc_plus_one),
    .out_valid       (out_valid),
    .out_has_imm     (out_has_imm),
    .imm_pending     (imm_pending)
  );

  always #5 clk = ~clk;

  function automatic obs_t sample();
    return {out_instruction, out_immediate, out_pc_plus_one,
            out_valid, out_has_imm, imm_pending};
  endfunction

  function automatic obs_t mk(input logic [15:0] i, input logic [15:0] m,
                              input logic [31:0] p, input logic v,
                              input logic h, input logic pend);
    return {i, m, p, v, h, pend};
  endfunction

  function automatic obs_t bubble(input logic pend);
    return mk(NOP, 16'h0000, 32'd0, 1'b0, 1'b0, pend);
  endfunction

  task automatic check(input string tag, input obs_t exp);
    obs_t obs;
    obs = sample();
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one fetch cycle at the falling edge, check just after the rising edge.
  task automatic step(input string tag, input logic fv, input logic [15:0] ins,
                      input logic [31:0] pc, input logic st, input logic fl,
                      input obs_t exp);
    @(negedge clk);
    fetch_valid = fv;
    instruction = ins;
    pc_plus_one = pc;
    stall       = st;
    flush       = fl;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    check(tag_q.pop_front(), exp_q.pop_front());
  endtask

  initial begin
    reset       = 1'b0;
    fetch_valid = 1'b0;
    instruction = '0;
    pc_plus_one = '0;
    stall       = 1'b0;
    flush       = 1'b0;

    // Reset held with random inputs toggling.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      fetch_valid = 1'($urandom);
      instruction = 16'($urandom);
      pc_plus_one = $urandom;
      stall       = 1'($urandom);
      flush       = 1'($urandom);
    end
    #1;
    check("reset_hold", bubble(1'b0));
    @(negedge clk);
    fetch_valid = 1'b0;
    stall       = 1'b0;
    flush       = 1'b0;
    reset       = 1'b1;
    #1;
    check("reset_release", bubble(1'b0));

    // One-word stream.
    step("one_word_a", 1, 16'h1234, 32'd33, 0, 0, mk(16'h1234, 16'h0, 32'd33, 1, 0, 0));
    step("one_word_b", 1, 16'h2246, 32'd34, 0, 0, mk(16'h2246, 16'h0, 32'd34, 1, 0, 0));

    // Two-word instruction; immediate has its own IMM_BIT set.
    step("two_word_first", 1, 16'h5001, 32'd40, 0, 0, bubble(1'b1));
    step("two_word_imm",   1, 16'hBEEF, 32'd41, 0, 0, mk(16'h5001, 16'hBEEF, 32'd41, 1, 1, 0));

    // Stall while a one-word instruction is on the outputs.
    step("pre_stall",  1, 16'h1234, 32'd33, 0, 0, mk(16'h1234, 16'h0, 32'd33, 1, 0, 0));
    step("stall_1",    1, 16'h7776, 32'd99, 1, 0, mk(16'h1234, 16'h0, 32'd33, 1, 0, 0));
    step("stall_2",    1, 16'h5001, 32'd98, 1, 0, mk(16'h1234, 16'h0, 32'd33, 1, 0, 0));
    step("stall_3",    0, 16'h0000, 32'd97, 1, 0, mk(16'h1234, 16'h0, 32'd33, 1, 0, 0));
    step("stall_release", 1, 16'h0ABC, 32'd50, 0, 0, mk(16'h0ABC, 16'h0, 32'd50, 1, 0, 0));

    // Flush with simultaneous stall while in S_IMM.
    step("flush_first",  1, 16'h5001, 32'd60, 0, 0, bubble(1'b1));
    step("flush_imm",    1, 16'hBEEF, 32'd61, 1, 1, bubble(1'b0));
    step("after_flush",  1, 16'h0002, 32'd62, 0, 0, mk(16'h0002, 16'h0, 32'd62, 1, 0, 0));

    // fetch_valid gap while waiting for an immediate.
    step("gap_first", 1, 16'h5001, 32'd70, 0, 0, bubble(1'b1));
    step("gap_1",     0, 16'h1111, 32'd0,  0, 0, bubble(1'b1));
    step("gap_2",     0, 16'h2223, 32'd0,  0, 0, bubble(1'b1));
    step("gap_imm",   1, 16'h00AA, 32'd71, 0, 0, mk(16'h5001, 16'h00AA, 32'd71, 1, 1, 0));

    // Idle fetch in S_INSTR gives a bubble.
    step("idle", 0, 16'h3330, 32'd5, 0, 0, bubble(1'b0));

    // Stall while parked in S_IMM keeps the pending word.
    step("stall_imm_first", 1, 16'h5001, 32'd80, 0, 0, bubble(1'b1));
    step("stall_imm_hold",  1, 16'h00BB, 32'd90, 1, 0, bubble(1'b1));
    step("stall_imm_done",  1, 16'h00CC, 32'd81, 0, 0, mk(16'h5001, 16'h00CC, 32'd81, 1, 1, 0));

    // Flush clears a valid one-word output.
    step("pre_flush",  1, 16'h1234, 32'd33, 0, 0, mk(16'h1234, 16'h0, 32'd33, 1, 0, 0));
    step("flush_word", 1, 16'h2246, 32'd34, 0, 1, bubble(1'b0));

    // Reset mid-operation discards the parked first word.
    step("rst_first", 1, 16'h5001, 32'd100, 0, 0, bubble(1'b1));
    @(negedge clk);
    fetch_valid = 1'b0;
    reset = 1'b0;
    #1;
    check("rst_async", bubble(1'b0));
    @(negedge clk);
    reset = 1'b1;
    step("rst_after", 1, 16'h0002, 32'd5, 0, 0, mk(16'h0002, 16'h0, 32'd5, 1, 0, 0));

    $display("%0d/%0d checks passed", n_pass, n_pass + n_fail);
    $finish;
  end

endmodule
